// File: rtl/uart_pkg.sv
// Shared UART constants: oversample ratio and standard 16x divisors for a 100 MHz clock.
package uart_pkg;

    localparam int unsigned OS_RATE = 16;
    localparam int unsigned OS_W    = 4;

    // Divisor-select mux inputs, clk cycles per 16x tick at 100 MHz
    localparam int unsigned DIV_9600   = 651;
    localparam int unsigned DIV_19200  = 326;
    localparam int unsigned DIV_38400  = 163;
    localparam int unsigned DIV_57600  = 109;
    localparam int unsigned DIV_115200 = 54;

endpackage

// File: rtl/mod_counter.sv
// Modulo counter: counts while en, wraps to zero at a runtime terminal value, clr has priority.
module mod_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_d, cnt_q;

    assign tc  = en & (cnt_q == term);
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tc) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud tick generator: 16x oversample tick and 1x bit tick from a mux-selected divisor.
// Optional BAUD_RESYNC_EN adds a resync input that realigns the tick phase.
module uart_baud_gen #(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned OS_RATE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
`ifdef BAUD_RESYNC_EN
    input  logic             resync,
`endif
    input  logic [DIV_W-1:0] div,
    output logic             tick_16x,
    output logic             tick_1x,
    output logic [3:0]       os_cnt,
    output logic             busy
);
    import uart_pkg::*;

    logic             busy_q;
    logic [DIV_W-1:0] div_d, div_q;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] pcnt;
    logic [DIV_W-1:0] pcnt_term;
    logic             run;
    logic             rise;
    logic             resync_hit;
    logic             pcnt_tc;
    logic             load;

    // busy_q is the registered en; a rise is en seen high with the generator not yet running
    assign run  = en & busy_q;
    assign rise = en & ~busy_q;
    assign busy = run;

`ifdef BAUD_RESYNC_EN
    assign resync_hit = resync & en;
`else
    assign resync_hit = 1'b0;
`endif

    assign div_eff   = (div == '0) ? DIV_W'(1) : div;
    assign pcnt_term = div_q - DIV_W'(1);

    // resync wins over a coincident terminal count
    assign tick_16x = pcnt_tc & ~resync_hit;
    assign load     = rise | tick_16x | resync_hit;

    always_comb begin
        div_d = div_q;
        if (load) begin
            div_d = div_eff;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            div_q  <= DIV_W'(1);
        end else begin
            busy_q <= en;
            div_q  <= div_d;
        end
    end

    mod_counter #(
        .WIDTH (DIV_W)
    ) u_pcnt (
        .clk   (clk),
        .reset (reset),
        .en    (run),
        .clr   (~run | resync_hit),
        .term  (pcnt_term),
        .cnt   (pcnt),
        .tc    (pcnt_tc)
    );

    mod_counter #(
        .WIDTH (OS_W)
    ) u_os_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (tick_16x),
        .clr   (~run | resync_hit),
        .term  (OS_W'(OS_RATE - 1)),
        .cnt   (os_cnt),
        .tc    (tick_1x)
    );

    // div_q only reloads when pcnt returns to zero, so pcnt never passes the terminal
    pcnt_in_range : assert property (@(posedge clk) disable iff (reset) pcnt <= pcnt_term);

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed self-checking bench for uart_baud_gen; cycle 0 is the first edge that sees en high.
module tb_uart_baud_gen;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] div;
    logic        tick_16x;
    logic        tick_1x;
    logic [3:0]  os_cnt;
    logic        busy;
`ifdef BAUD_RESYNC_EN
    logic        resync;
`endif

    int total;
    int bad;

    uart_baud_gen #(
        .DIV_W   (16),
        .OS_RATE (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
`ifdef BAUD_RESYNC_EN
        .resync   (resync),
`endif
        .div      (div),
        .tick_16x (tick_16x),
        .tick_1x  (tick_1x),
        .os_cnt   (os_cnt),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Idle two cycles, then raise en so the next edge is cycle 0
    task automatic restart(input logic [15:0] d);
        en = 1'b0;
        cyc();
        cyc();
        div = d;
        en  = 1'b1;
    endtask

    task automatic test_reset();
        logic exp_t;
        #1;
        total++;
        if ({tick_16x, tick_1x, os_cnt, busy} !== 7'd0) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=0", {tick_16x, tick_1x, os_cnt, busy});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        div = 16'd4;
        en  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            exp_t = (c % 4) == 3;
            total++;
            if (tick_16x !== exp_t) begin
                bad++;
                $display("FAIL pre_reset_tick c=%0d got=%b exp=%b", c, tick_16x, exp_t);
            end
        end
        total++;
        if (os_cnt !== 4'd2) begin
            bad++;
            $display("FAIL pre_reset_os got=%0d exp=2", os_cnt);
        end
        #3 reset = 1'b1;
        #1;
        total++;
        if ({tick_16x, tick_1x, os_cnt, busy} !== 7'd0) begin
            bad++;
            $display("FAIL async_reset got=%b exp=0", {tick_16x, tick_1x, os_cnt, busy});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            exp_t = (c % 4) == 3;
            total++;
            if (tick_16x !== exp_t || busy !== 1'b1) begin
                bad++;
                $display("FAIL post_reset c=%0d got=%b%b exp=%b1", c, tick_16x, busy, exp_t);
            end
        end
    endtask

    task automatic test_div4_run();
        logic       exp_t, exp_x;
        logic [3:0] exp_os;
        int         n16, n1;
        n16 = 0;
        n1  = 0;
        restart(16'd4);
        for (int c = 0; c < 80; c++) begin
            cyc();
            exp_os = 4'((c / 4) % 16);
            exp_t  = (c % 4) == 3;
            exp_x  = exp_t && (exp_os == 4'd15);
            n16 += int'(tick_16x);
            n1  += int'(tick_1x);
            total++;
            if (tick_16x !== exp_t || tick_1x !== exp_x || os_cnt !== exp_os) begin
                bad++;
                $display("FAIL div4 c=%0d got=%b%b/%0d exp=%b%b/%0d", c, tick_16x, tick_1x,
                         os_cnt, exp_t, exp_x, exp_os);
            end
        end
        total++;
        if (n16 != 20 || n1 != 1) begin
            bad++;
            $display("FAIL div4_counts got=%0d/%0d exp=20/1", n16, n1);
        end
    endtask

    task automatic test_div0();
        logic       exp_x;
        logic [3:0] exp_os;
        restart(16'd0);
        for (int c = 0; c < 40; c++) begin
            cyc();
            exp_os = 4'(c % 16);
            exp_x  = exp_os == 4'd15;
            total++;
            if (tick_16x !== 1'b1 || tick_1x !== exp_x || os_cnt !== exp_os) begin
                bad++;
                $display("FAIL div0 c=%0d got=%b%b/%0d exp=1%b/%0d", c, tick_16x, tick_1x,
                         os_cnt, exp_x, exp_os);
            end
        end
    endtask

    task automatic test_div_change();
        logic exp_t;
        restart(16'd10);
        for (int c = 0; c < 21; c++) begin
            cyc();
            exp_t = (c == 9) || (c >= 12 && ((c - 12) % 3) == 0);
            total++;
            if (tick_16x !== exp_t) begin
                bad++;
                $display("FAIL div_change c=%0d got=%b exp=%b", c, tick_16x, exp_t);
            end
            if (c == 5) div = 16'd3;
        end
    endtask

    task automatic test_simultaneous();
        logic exp_t;
        restart(16'd5);
        for (int c = 0; c < 11; c++) begin
            cyc();
            exp_t = (c == 4) || (c >= 6 && (c % 2) == 0);
            total++;
            if (tick_16x !== exp_t) begin
                bad++;
                $display("FAIL simul_change c=%0d got=%b exp=%b", c, tick_16x, exp_t);
            end
            if (c == 4) div = 16'd2;
        end
    endtask

    task automatic test_en_drop();
        logic exp_t;
        restart(16'd6);
        for (int c = 0; c < 15; c++) begin
            cyc();
            exp_t = (c % 6) == 5;
            total++;
            if (tick_16x !== exp_t) begin
                bad++;
                $display("FAIL en_run c=%0d got=%b exp=%b", c, tick_16x, exp_t);
            end
        end
        total++;
        if (os_cnt !== 4'd2) begin
            bad++;
            $display("FAIL en_pre_drop_os got=%0d exp=2", os_cnt);
        end
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            total++;
            if ({tick_16x, tick_1x, os_cnt, busy} !== 7'd0) begin
                bad++;
                $display("FAIL en_low c=%0d got=%b exp=0", c, {tick_16x, tick_1x, os_cnt, busy});
            end
        end
        en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            exp_t = c == 5;
            total++;
            if (tick_16x !== exp_t || os_cnt !== 4'd0) begin
                bad++;
                $display("FAIL en_reraise c=%0d got=%b/%0d exp=%b/0", c, tick_16x, os_cnt, exp_t);
            end
        end
    endtask

`ifdef BAUD_RESYNC_EN
    task automatic test_resync();
        logic exp_t;
        restart(16'd8);
        for (int c = 0; c < 14; c++) begin
            cyc();
            if (c == 13) begin
                total++;
                if (os_cnt !== 4'd1) begin
                    bad++;
                    $display("FAIL resync_pre_os got=%0d exp=1", os_cnt);
                end
                resync = 1'b1;
            end
        end
        for (int c = 14; c < 23; c++) begin
            cyc();
            resync = 1'b0;
            exp_t  = c == 21;
            total++;
            if (tick_16x !== exp_t || (c <= 21 && os_cnt !== 4'd0)) begin
                bad++;
                $display("FAIL resync c=%0d got=%b/%0d exp=%b/0", c, tick_16x, os_cnt, exp_t);
            end
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        en    = 1'b0;
        div   = 16'd0;
`ifdef BAUD_RESYNC_EN
        resync = 1'b0;
`endif
        test_reset();
        test_div4_run();
        test_div0();
        test_div_change();
        test_simultaneous();
        test_en_drop();
`ifdef BAUD_RESYNC_EN
        test_resync();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Baud-rate tick generator. It consumes the N-bit divisor chosen by the upstream 8:1 divisor-select mux; the mux output drives div. It produces a 16x-oversample tick for the UART receiver and a 1x bit tick for the UART transmitter. A rate change on the mux select is absorbed cleanly at the next period boundary.

Parameters:
DIV_W, 16, divisor width; matches N of the upstream mux instance.
OS_RATE, 16, oversample ratio; fixed at 16, power of two required.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  1  generator enable; low holds the counters cleared
div  input  DIV_W  clk cycles per 16x tick, taken from the mux output
tick_16x  output  1  one-cycle pulse every div_q cycles
tick_1x  output  1  one-cycle pulse, coincident with every 16th tick_16x
os_cnt  output  4  oversample phase, 0..15
busy  output  1  high while en=1 and the generator is running

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset state: all registers clear. div_q=1, period counter pcnt=0, os_cnt=0, tick_16x=0, tick_1x=0, busy=0.
- Divisor sampling:
  - div_q loads max(div,1): div=0 is treated as 1, giving a tick every cycle.
  - Loads at the rising edge of en (en low→high between consecutive clk edges).
  - Also loads on every cycle in which tick_16x is asserted.
  - A div change mid-period has no effect until the current period completes.
- Run (en=1):
  - pcnt increments each cycle.
  - When pcnt==div_q-1: pcnt→0 and tick_16x=1 for exactly that cycle (combinational decode of registered state, no extra latency).
  - os_cnt increments mod 16 on each tick_16x.
  - tick_1x = tick_16x & (os_cnt==15).
- First-tick latency: with en high at edge k, the first tick_16x is in cycle k+div_q-1. The first tick_1x follows 16 tick periods after that.
- Idle (en=0): pcnt=0, os_cnt=0, both ticks 0, busy=0, div_q held. Deasserting en mid-period aborts the period with no partial tick.
- Arithmetic: pcnt is DIV_W bits and wraps only through the terminal compare, never by overflow. div=all-ones gives a period of 2^DIV_W-1.
- Reset mid-operation: immediate return to the reset state. Upon release, en high restarts as an enable rising edge.
- Simultaneous events: a div change in the same cycle as tick_16x is captured (the new value applies to the next period).

Optional Feature:
BAUD_RESYNC_EN
- Defined:
  - Adds input resync (1 bit).
  - resync=1 with en=1 clears pcnt and os_cnt and reloads div_q from div.
  - Next tick_16x occurs exactly max(div,1) cycles after the resync cycle.
  - resync has priority over a coincident tick: that tick is suppressed.
  - Used by the receiver to align phase on the start-bit falling edge.
- Undefined: the resync port does not exist and phase is free-running.

Decomposition:
- Package uart_pkg holds:
  - OS_RATE=16 and OS_W=4.
  - Standard divisor constants for 100 MHz clk at 16x: DIV_9600=651, DIV_19200=326, DIV_38400=163, DIV_57600=109, DIV_115200=54. These feed the mux inputs.
- One sub-module, mod_counter (parameterised width, terminal value, enable, clear; outputs count and terminal pulse). Instantiated twice: once for pcnt, once for os_cnt.

Test Plan:
- Reset asserted mid-run, async between edges → all outputs 0 immediately. After release with en=1, div=4: tick_16x at cycles 3,7,11…
- div=4, en=1 for 80 cycles → 20 tick_16x pulses, 1 tick_1x on the 16th, os_cnt sequence 0..15,0…
- div=0 → tick_16x every cycle, tick_1x every 16 cycles.
- div changes 10→3 at pcnt=5 → current period still 10 cycles, following periods 3 cycles.
- en dropped at pcnt=2 with div=6, re-raised 5 cycles later → no tick while low, os_cnt=0, first tick 6 cycles after re-raise.
- BAUD_RESYNC_EN defined, div=8, resync pulsed at pcnt=5 → no tick at the old terminal, next tick_16x 8 cycles after resync, os_cnt restarts at 0.
